instr_feeder: RTL and testbench

INSTR_FEEDER -- requirements
Module: instr_feeder

---
 rtl/i2o2_pkg.sv | 24 ++
 rtl/key_debounce.sv | 117 +++++++++++
 rtl/instr_feeder.sv | 109 ++++++++++
 tb/tb_instr_feeder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2o2_pkg.sv
// -----------------------------------------------------------------------------
// i2o2_pkg
// Shared definitions for the instruction-entry front end.
//   WORD_W      : width of an instruction word and of the PC tag
//   db_state_t  : key debounce FSM state encoding
//   pc_next     : PC tag successor (wraps 0xFFFF -> 0x0000)
// -----------------------------------------------------------------------------
package i2o2_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_HELD         = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_t;

    // Natural modulo-2^WORD_W increment; the carry out is simply dropped.
    function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes the raw push-button and switch bank, then debounces the button
// with a four-state FSM. Emits a single-cycle accept pulse per press.
// Ports:
//   clock    in   single clock, all state on posedge
//   reset_n  in   asynchronous active-low reset
//   key_n    in   raw active-low push-button (asynchronous, bouncing)
//   sw       in   raw switch bank (asynchronous)
//   sw_sync  out  switch bank after 2-flop synchronizer
//   accept   out  one-cycle pulse on PRESS_WAIT -> HELD
// -----------------------------------------------------------------------------
import i2o2_pkg::*;

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              key_n,
    input  logic [WORD_W-1:0] sw,
    output logic [WORD_W-1:0] sw_sync,
    output logic              accept
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic              key_p0;
    logic              key_p1;
    logic [WORD_W-1:0] sw_p0;
    logic [WORD_W-1:0] sw_p1;

    db_state_t         state;
    db_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    // ---- stage p0/p1: two-flop synchronizers (key idles released = 1) ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            sw_p0  <= '0;
            sw_p1  <= '0;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
        end
    end

    assign sw_sync = sw_p1;

    // ---- debounce FSM state register ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= DB_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt holds the number of consecutive qualifying samples already seen in
    // the current wait state; the DEBOUNCE_CYCLES-th one causes the transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            DB_IDLE: begin
                if (!key_p1) begin
                    state_nxt = DB_PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (key_p1) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DB_HELD;
                    cnt_nxt   = '0;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DB_HELD: begin
                if (key_p1) begin
                    state_nxt = DB_RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            DB_RELEASE_WAIT: begin
                if (!key_p1) begin
                    // Bounce during release: back to HELD, no new accept.
                    state_nxt = DB_HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_feeder.sv
// -----------------------------------------------------------------------------
// instr_feeder
// Captures the switch bank as an instruction word on each debounced press of
// KEY[0], buffers it in a small FIFO and offers it to the fetch stage with a
// valid/ready handshake, tagging each head word with a running PC.
// Ports:
//   clock          in   single clock
//   reset_n        in   asynchronous active-low reset
//   key0_n         in   raw push-button, active low
//   sw             in   raw switches holding the word to enter
//   palavra        out  FIFO head word (0 when empty)
//   palavra_valid  out  head word is undelivered
//   palavra_ready  in   fetch stage takes the head this cycle
//   pc_tag         out  PC associated with the head word
//   fifo_count     out  number of buffered words
//   overflow       out  sticky: a press was dropped on a full FIFO
// -----------------------------------------------------------------------------
import i2o2_pkg::*;

module instr_feeder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          key0_n,
    input  logic [WORD_W-1:0]             sw,
    output logic [WORD_W-1:0]             palavra,
    output logic                          palavra_valid,
    input  logic                          palavra_ready,
    output logic [WORD_W-1:0]             pc_tag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [WORD_W-1:0] sw_sync;
    logic              accept;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key0_n),
        .sw      (sw),
        .sw_sync (sw_sync),
        .accept  (accept)
    );

    assign palavra_valid = (fifo_count != '0);
    assign full          = (fifo_count == CNT_FULL);
    assign pop           = palavra_valid && palavra_ready;
    // A simultaneous pop frees the slot the accepted word needs, so a full
    // FIFO only drops when nothing leaves in the same cycle.
    assign push          = accept && (!full || pop);
    assign drop          = accept && full && !pop;

    // Head is masked when empty so stale storage never shows on palavra.
    assign palavra = palavra_valid ? mem[rd_ptr] : '0;

    // ---- storage write (data path, not reset) ----
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= sw_sync;
        end
    end

    // ---- FIFO control, PC tag and overflow flag ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pc_tag     <= '0;
            overflow   <= 1'b0;
        end else begin
            // Pointers wrap naturally: FIFO_DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                pc_tag <= pc_next(pc_tag);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// -----------------------------------------------------------------------------
// tb_instr_feeder
// Scoreboard bench for instr_feeder (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// Stimulus pushes expected words into exp_q; a monitor pops and compares on
// every valid&&ready handshake, tracking its own expected PC.
// -----------------------------------------------------------------------------
module tb_instr_feeder;

    localparam int DB    = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        key0_n;
    logic [15:0] sw;
    logic [15:0] palavra;
    logic        palavra_valid;
    logic        palavra_ready;
    logic [15:0] pc_tag;
    logic [2:0]  fifo_count;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_pc = 16'h0000;

    always #5 clock = ~clock;

    instr_feeder #(
        .DEBOUNCE_CYCLES (DB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .key0_n        (key0_n),
        .sw            (sw),
        .palavra       (palavra),
        .palavra_valid (palavra_valid),
        .palavra_ready (palavra_ready),
        .pc_tag        (pc_tag),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each handshake seen here completes on the following posedge.
    always @(negedge clock) begin
        if (reset_n && palavra_valid && palavra_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xfer: got word 0x%0h, expected no transfer", palavra);
            end else begin
                chk("xfer_word", {16'h0, palavra}, {16'h0, exp_q[0]});
                chk("xfer_pc", {16'h0, pc_tag}, {16'h0, exp_pc});
                void'(exp_q.pop_front());
                exp_pc = exp_pc + 16'h1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"},    {31'h0, palavra_valid}, 32'h0);
        chk({tag, "_palavra"},  {16'h0, palavra},       32'h0);
        chk({tag, "_pc_tag"},   {16'h0, pc_tag},        32'h0);
        chk({tag, "_count"},    {29'h0, fifo_count},    32'h0);
        chk({tag, "_overflow"}, {31'h0, overflow},      32'h0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        palavra_ready = 1'b0;
        key0_n        = 1'b1;
        sw            = 16'h0000;
        reset_n       = 1'b0;
        exp_q.delete();
        exp_pc = 16'h0000;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_values("rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick(2);
    endtask

    // Clean press: key low for 'hold' cycles, then released for 10 cycles.
    task automatic press(input logic [15:0] word, input bit expect_push);
        sw     = word;
        key0_n = 1'b0;
        if (expect_push) exp_q.push_back(word);
        tick(10);
        key0_n = 1'b1;
        tick(10);
    endtask

    initial begin
        reset_n       = 1'b0;
        key0_n        = 1'b1;
        sw            = 16'h0000;
        palavra_ready = 1'b0;

        // ---- reset state ----
        do_reset();

        // ---- single clean press, fetch stalled ----
        press(16'h1A2B, 1'b1);
        chk("single_count", {29'h0, fifo_count}, 32'd1);
        chk("single_valid", {31'h0, palavra_valid}, 32'd1);
        chk("single_word", {16'h0, palavra}, 32'h1A2B);
        chk("single_pc", {16'h0, pc_tag}, 32'h0);
        tick(3);
        chk("single_stable", {16'h0, palavra}, 32'h1A2B);
        palavra_ready = 1'b1;
        tick(3);
        palavra_ready = 1'b0;
        chk("single_drained", {29'h0, fifo_count}, 32'd0);
        chk("single_pc_after", {16'h0, pc_tag}, 32'h1);
        chk("single_palavra_empty", {16'h0, palavra}, 32'h0);
        // ready while empty must not move the PC
        palavra_ready = 1'b1;
        tick(3);
        palavra_ready = 1'b0;
        chk("empty_ready_pc", {16'h0, pc_tag}, 32'h1);

        // ---- bouncing key never stable for 4 cycles ----
        sw = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            key0_n = 1'b0;
            tick(2);
            key0_n = 1'b1;
            tick(2);
        end
        tick(20);
        chk("bounce_count", {29'h0, fifo_count}, 32'd0);
        chk("bounce_valid", {31'h0, palavra_valid}, 32'd0);

        // ---- overflow: five presses into a four-entry FIFO ----
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            press(16'(i), i <= 4);
        end
        chk("ovf_count", {29'h0, fifo_count}, 32'd4);
        chk("ovf_flag", {31'h0, overflow}, 32'd1);
        chk("ovf_head", {16'h0, palavra}, 32'h0001);
        palavra_ready = 1'b1;
        tick(6);
        palavra_ready = 1'b0;
        chk("ovf_drained_valid", {31'h0, palavra_valid}, 32'd0);
        chk("ovf_drained_pc", {16'h0, pc_tag}, 32'd4);
        chk("ovf_sticky", {31'h0, overflow}, 32'd1);

        // ---- full FIFO: accept coincides with a pop ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press(16'h0011 + 16'(i), 1'b1);
        end
        chk("full_count", {29'h0, fifo_count}, 32'd4);
        sw     = 16'h0015;
        key0_n = 1'b0;
        exp_q.push_back(16'h0015);
        tick(6);                 // accept is active during the next cycle
        palavra_ready = 1'b1;
        tick(1);
        palavra_ready = 1'b0;
        chk("both_count", {29'h0, fifo_count}, 32'd4);
        chk("both_overflow", {31'h0, overflow}, 32'd0);
        chk("both_head", {16'h0, palavra}, 32'h0012);
        tick(8);                 // keep holding: no further pulses
        key0_n = 1'b1;
        tick(10);
        chk("held_no_repeat", {29'h0, fifo_count}, 32'd4);
        palavra_ready = 1'b1;
        tick(6);
        palavra_ready = 1'b0;
        chk("both_drained", {31'h0, palavra_valid}, 32'd0);

        // ---- PC wrap 0xFFFF -> 0x0000 ----
        do_reset();
        force dut.pc_tag = 16'hFFFF;
        tick(1);
        release dut.pc_tag;
        exp_pc = 16'hFFFF;
        tick(1);
        chk("wrap_preload", {16'h0, pc_tag}, 32'hFFFF);
        press(16'h55AA, 1'b1);
        palavra_ready = 1'b1;
        tick(3);
        palavra_ready = 1'b0;
        chk("wrap_pc", {16'h0, pc_tag}, 32'h0000);
        chk("wrap_count", {29'h0, fifo_count}, 32'd0);

        // ---- reset asserted mid-press with two words buffered ----
        do_reset();
        press(16'h0021, 1'b1);
        press(16'h0022, 1'b1);
        chk("mid_pre_count", {29'h0, fifo_count}, 32'd2);
        sw     = 16'h0023;
        key0_n = 1'b0;
        tick(4);                 // debouncer now in PRESS_WAIT
        reset_n = 1'b0;
        exp_q.delete();
        exp_pc = 16'h0000;
        @(negedge clock);
        check_reset_values("mid_rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick(6);
        chk("mid_no_early_push", {29'h0, fifo_count}, 32'd0);
        exp_q.push_back(16'h0023);
        tick(1);
        chk("mid_push_count", {29'h0, fifo_count}, 32'd1);
        chk("mid_push_word", {16'h0, palavra}, 32'h0023);
        key0_n = 1'b1;
        tick(10);
        palavra_ready = 1'b1;
        tick(3);
        palavra_ready = 1'b0;
        chk("mid_pc", {16'h0, pc_tag}, 32'h1);

        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
